// File: rtl/switch_fe_pkg.sv
// switch_fe_pkg: shared frame field offsets, broadcast constant and MAC table entry type
package switch_fe_pkg;
    localparam int MAC_W        = 48;
    localparam int ENTRY_PORT_W = 4;
    localparam int SRC_LSB      = 0;
    localparam int DST_LSB      = 48;
    localparam logic [MAC_W-1:0] BCAST_MAC = '1;

    typedef struct packed {
        logic                    valid;
        logic [MAC_W-1:0]        mac;
        logic [ENTRY_PORT_W-1:0] port;
    } mac_entry_t;
endpackage

// File: rtl/mac_learn_table.sv
// mac_learn_table: fully associative MAC table with parallel lookup, station-move update and round-robin replacement
module mac_learn_table
    import switch_fe_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MAC_W-1:0]        lookup_mac,
    output logic                    hit,
    output logic [ENTRY_PORT_W-1:0] hit_port,
    input  logic                    learn_en,
    input  logic [MAC_W-1:0]        learn_mac,
    input  logic [ENTRY_PORT_W-1:0] learn_port
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mac_entry_t       tbl [DEPTH];
    logic [IDX_W-1:0] rep_ptr;
    logic             src_hit;
    logic [IDX_W-1:0] src_idx;
    logic             free;
    logic [IDX_W-1:0] free_idx;
    logic             learn_ok;

    // Descending scan so the lowest-index free entry wins
    always_comb begin
        hit      = 1'b0;
        hit_port = '0;
        src_hit  = 1'b0;
        src_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].mac == lookup_mac) begin
                hit      = 1'b1;
                hit_port = tbl[i].port;
            end
            if (tbl[i].valid && tbl[i].mac == learn_mac) begin
                src_hit = 1'b1;
                src_idx = IDX_W'(i);
            end
            if (!tbl[i].valid) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign learn_ok = learn_en && learn_mac != BCAST_MAC && learn_mac != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
            rep_ptr <= '0;
        end else if (learn_ok) begin
            if (src_hit)
                tbl[src_idx].port <= learn_port;
            else if (free)
                tbl[free_idx] <= '{valid: 1'b1, mac: learn_mac, port: learn_port};
            else begin
                tbl[rep_ptr] <= '{valid: 1'b1, mac: learn_mac, port: learn_port};
                rep_ptr      <= (rep_ptr == IDX_W'(DEPTH - 1)) ? '0 : rep_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_forwarding_frontend.sv
// switch_forwarding_frontend: ingress lane select, MAC learn/lookup and registered egress forwarding decision
module switch_forwarding_frontend
    import switch_fe_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int PORTS       = 16,
    parameter int ADDR_W      = 48,
    parameter int TABLE_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in [PORTS],
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(PORTS)-1:0]   out_in_port,
    output logic [$clog2(PORTS)-1:0]   out_port,
    output logic                       out_found,
    output logic                       out_flood,
    output logic [PORTS-1:0]           out_mask,
    output logic                       collision
);
    localparam int PORT_W = $clog2(PORTS);

    logic              sel_valid;
    logic [PORT_W-1:0] sel_port;
    logic              multi;
    logic              ing_valid;
    logic [WIDTH-1:0]  ing_data;
    logic [PORT_W-1:0] ing_port;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic              hit;
    logic [PORT_W-1:0] hit_port;
    logic              hit_eff;
    logic              fwd;
    logic              flood;
    logic [PORTS-1:0]  mask_n;

    // Ascending scan: the highest active lane is the one left selected
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = '0;
        multi     = 1'b0;
        for (int i = 0; i < PORTS; i++)
            if (data_in[i] != '0) begin
                multi     = multi | sel_valid;
                sel_valid = 1'b1;
                sel_port  = PORT_W'(i);
            end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ing_valid <= 1'b0;
            ing_data  <= '0;
            ing_port  <= '0;
            collision <= 1'b0;
        end else begin
            ing_valid <= sel_valid;
            ing_data  <= data_in[sel_port];
            ing_port  <= sel_port;
            collision <= multi;
        end
    end

    assign src = ing_data[SRC_LSB +: ADDR_W];
    assign dst = ing_data[DST_LSB +: ADDR_W];

    mac_learn_table #(
        .DEPTH(TABLE_DEPTH)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .lookup_mac(dst),
        .hit       (hit),
        .hit_port  (hit_port),
        .learn_en  (ing_valid),
        .learn_mac (src),
        .learn_port(ing_port)
    );

    // A hit back to the ingress port is filtered: valid frame, empty mask
    always_comb begin
        hit_eff = hit && dst != BCAST_MAC;
        fwd     = hit_eff && hit_port != ing_port;
        flood   = !hit_eff;
        mask_n  = !ing_valid ? '0 :
                  fwd        ? PORTS'(1) << hit_port :
                  flood      ? ~(PORTS'(1) << ing_port) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_in_port <= '0;
            out_port    <= '0;
            out_found   <= 1'b0;
            out_flood   <= 1'b0;
            out_mask    <= '0;
        end else begin
            out_valid <= ing_valid;
            out_found <= ing_valid && fwd;
            out_flood <= ing_valid && flood;
            out_mask  <= mask_n;
            if (ing_valid) begin
                out_data    <= ing_data;
                out_in_port <= ing_port;
                out_port    <= fwd ? hit_port : '0;
            end
        end
    end
endmodule

// File: tb/tb_switch_forwarding_frontend.sv
// tb_switch_forwarding_frontend: directed vectors with hand-computed forwarding decisions
module tb_switch_forwarding_frontend;
    localparam int WIDTH  = 128;
    localparam int PORTS  = 16;
    localparam int PORT_W = 4;
    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] A  = 48'h0000_0A0A_0001;
    localparam logic [47:0] B  = 48'h0000_0B0B_0002;
    localparam logic [47:0] C  = 48'h0000_0C0C_0003;
    localparam logic [47:0] D  = 48'h0000_0D0D_0004;
    localparam logic [47:0] E  = 48'h0000_0E0E_0005;
    localparam logic [47:0] F  = 48'h0000_0F0F_0006;
    localparam logic [47:0] G  = 48'h0000_1010_0007;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  data_in [PORTS];
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [PORT_W-1:0] out_in_port;
    logic [PORT_W-1:0] out_port;
    logic              out_found;
    logic              out_flood;
    logic [PORTS-1:0]  out_mask;
    logic              collision;
    int                n_vec = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    switch_forwarding_frontend dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_in_port(out_in_port),
        .out_port   (out_port),
        .out_found  (out_found),
        .out_flood  (out_flood),
        .out_mask   (out_mask),
        .collision  (collision)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] frame(input logic [47:0] s, input logic [47:0] d, input logic [31:0] t);
        return {t, d, s};
    endfunction

    task automatic idle();
        foreach (data_in[i]) data_in[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [47:0] s, input logic [47:0] d, input logic [31:0] t);
        idle();
        data_in[p] = frame(s, d, t);
        step();
        idle();
    endtask

    task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] dat, input int ip,
                             input int op, input logic fnd, input logic fld, input logic [PORTS-1:0] msk);
        check({tag, ".valid"}, out_valid, v);
        check({tag, ".data"}, out_data, dat);
        check({tag, ".in_port"}, out_in_port, ip);
        check({tag, ".found"}, out_found, fnd);
        check({tag, ".flood"}, out_flood, fld);
        check({tag, ".mask"}, out_mask, msk);
        if (fnd) check({tag, ".port"}, out_port, op);
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", out_valid, 0);
        check("rst.data", out_data, 0);
        check("rst.mask", out_mask, 0);
        check("rst.collision", collision, 0);
        @(negedge clk);
        reset = 1'b0;

        send(3, A, B, 1); step();
        check_out("learn_a", 1, frame(A, B, 1), 3, 0, 0, 1, 16'hFFF7);
        send(5, B, A, 2); step();
        check_out("ucast_a", 1, frame(B, A, 2), 5, 3, 1, 0, 16'h0008);

        send(2, C, BC, 3); step();
        check_out("bcast", 1, frame(C, BC, 3), 2, 0, 0, 1, 16'hFFFB);
        send(6, 48'h0, C, 4); step();
        check_out("ucast_c", 1, frame(48'h0, C, 4), 6, 2, 1, 0, 16'h0004);

        send(3, D, A, 5); step();
        check_out("filter", 1, frame(D, A, 5), 3, 0, 0, 0, 16'h0000);
        send(7, A, B, 6); step();
        check_out("move_src", 1, frame(A, B, 6), 7, 5, 1, 0, 16'h0020);
        send(1, E, A, 7); step();
        check_out("moved_a", 1, frame(E, A, 7), 1, 7, 1, 0, 16'h0080);

        idle();
        data_in[1] = frame(G, B, 8);
        data_in[9] = frame(F, A, 9);
        step();
        idle();
        check("coll.pulse", collision, 1);
        step();
        check("coll.clear", collision, 0);
        check_out("coll", 1, frame(F, A, 9), 9, 7, 1, 0, 16'h0080);
        send(10, 48'h0, G, 10); step();
        check_out("dropped_g", 1, frame(48'h0, G, 10), 10, 0, 0, 1, 16'hFBFF);
        step();
        check("idle.valid", out_valid, 0);
        check("idle.mask", out_mask, 0);
        check("idle.flood", out_flood, 0);
        check("idle.hold", out_data, frame(48'h0, G, 10));

        idle();
        data_in[4] = frame(C, D, 11);
        step();
        idle();
        data_in[5] = frame(D, C, 12);
        step();
        idle();
        check("pre_rst.valid", out_valid, 1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst.valid", out_valid, 0);
        check("mid_rst.data", out_data, 0);
        check("mid_rst.in_port", out_in_port, 0);
        check("mid_rst.found", out_found, 0);
        check("mid_rst.mask", out_mask, 0);
        @(negedge clk);
        reset = 1'b0;
        send(0, A, A, 13);
        check("post_rst.idle", out_valid, 0);
        step();
        check_out("self_a", 1, frame(A, A, 13), 0, 0, 0, 1, 16'hFFFE);

        for (int i = 1; i <= 16; i++) send(4, 48'h0000_5500_0000 + 48'(i), BC, 32'(100 + i));
        idle();
        data_in[8] = frame(48'h0, A, 200);
        step();
        data_in[8] = frame(48'h0, 48'h0000_5500_0010, 201);
        step();
        check_out("full_a", 1, frame(48'h0, A, 200), 8, 0, 0, 1, 16'hFEFF);
        data_in[8] = frame(48'h0, 48'h0000_5500_0001, 202);
        step();
        idle();
        check_out("full_17", 1, frame(48'h0, 48'h0000_5500_0010, 201), 8, 4, 1, 0, 16'h0010);
        step();
        check_out("full_1", 1, frame(48'h0, 48'h0000_5500_0001, 202), 8, 4, 1, 0, 16'h0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/switch_forwarding_frontend.md
Name: switch_forwarding_frontend

Overview:
Front end of the L2 switch datapath.
- Ingress stage: selects one active frame per cycle from the PORTS input lanes.
- Learning stage: a MAC table learns source-address to port bindings and looks up the destination address.
- Egress stage: registers the frame together with its forwarding decision (unicast, flood or filter) for the downstream buffer memory and queues.

Parameters:
WIDTH, 128, frame word width in bits; must be >= 96.
PORTS, 16, number of switch ports; PORT_W = $clog2(PORTS) is a derived localparam.
ADDR_W, 48, MAC address width.
TABLE_DEPTH, 16, number of MAC table entries.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
data_in  in  PORTS x WIDTH  unpacked array of per-port frame words; a word equal to all-zero means idle.
out_valid  out  1  a frame decision is present this cycle.
out_data  out  WIDTH  forwarded frame word.
out_in_port  out  PORT_W  ingress port of the frame.
out_port  out  PORT_W  destination port; meaningful only when out_found=1.
out_found  out  1  destination address hit in the table on a port other than the ingress port.
out_flood  out  1  frame is flooded (broadcast destination or miss).
out_mask  out  PORTS  egress port mask.
collision  out  1  pulses for one cycle when more than one lane was active (frames dropped).

Behaviour:
- Frame fields: src MAC = word[47:0]; dst MAC = word[95:48]; remaining bits are opaque payload.
- Reset (asynchronous): all outputs 0, all table entries invalid, replacement pointer 0.
- Stage 1, ingress register: each cycle, the highest-index lane with a non-zero word is captured, giving ing_valid, ing_data and ing_port.
  - Other active lanes that cycle are dropped; collision=1 is registered alongside.
  - With no active lane, ing_valid=0.
- Lookup, combinational on stage 1 against the current table contents.
  - Hit: a valid entry's mac equals dst.
  - dst = all-ones (broadcast) is always treated as flood, regardless of the table.
- Stage 2, egress register: outputs update 1 cycle after stage 1, so data_in to outputs is 2 clocks. out_data, out_in_port and all decision outputs are cycle-aligned.
  - Hit with entry port != ing_port: out_found=1, out_port=entry port, out_mask=one-hot(out_port), out_flood=0.
  - Hit with entry port == ing_port (filter): out_found=0, out_flood=0, out_mask=0, out_valid=1.
  - Miss or broadcast: out_flood=1, out_found=0, out_mask = all ones except bit ing_port.
  - ing_valid=0: out_valid=0, out_mask=0, out_found=0, out_flood=0, out_data holds its previous value.
- Learning: on the same edge that registers stage 2, if ing_valid=1 and src is neither all-ones nor zero:
  - If src is present: update that entry's port to ing_port (station move).
  - Else, if a free entry exists: write src into the lowest-index invalid entry.
  - Else (table full): overwrite the entry at the replacement pointer, then increment the pointer modulo TABLE_DEPTH.
- Ordering: a lookup in cycle N sees learns committed at the end of cycle N-1, not the learn of the same frame. A frame with dst == src of an unknown station therefore floods.
- Back-to-back frames are accepted every cycle; there is no backpressure and no stall.
- Reset asserted mid-stream clears the pipeline and the table immediately. The first frame after deassertion appears 2 clocks later.

Decomposition:
- Package switch_fe_pkg: field offsets (SRC_LSB=0, DST_LSB=48), BCAST_MAC constant, and the mac_entry_t struct {valid, mac[ADDR_W], port[PORT_W]}.
- One sub-module, mac_learn_table: entry array, parallel compare, hit/port outputs, learn/replace logic.
- Ingress select and egress registers stay in the top module.

Test Plan:
- Reset: assert reset mid-traffic -> all outputs 0 immediately. After release, send frame src=A dst=A on port 0 -> floods (A was learned only by that same frame, not by the lookup).
- Learn/unicast: port 3 sends src=A dst=B -> out_flood=1, out_mask=16'hFFF7 at +2 clocks. Then port 5 sends src=B dst=A -> out_found=1, out_port=3, out_mask=16'h0008.
- Broadcast: port 2 sends dst=FFFF_FFFF_FFFF with A already learned -> out_flood=1, out_mask=16'hFFFB; the broadcast dst is never learned.
- Filter and station move: A learned on port 3; port 3 sends dst=A -> out_valid=1, out_mask=0. Then A re-sourced on port 7; a frame to A -> out_port=7.
- Collision: ports 1 and 9 active in the same cycle -> port 9's frame forwarded, out_in_port=9, collision=1; port 1's frame dropped.
- Table full: learn 17 distinct sources -> the 17th overwrites entry 0, so a lookup for the first source floods and a lookup for the 17th hits.
